// File: rtl/aer_spike_encoder.sv
// ---------------------------------------------------------------------------
// aer_spike_encoder
//   Holds one input image and converts its pixel intensities into input spike
//   events using deterministic rate coding. A per-pixel 8-bit accumulator
//   takes the pixel value on every timestep, and the pixel spikes whenever the
//   accumulator overflows. Over T timesteps a pixel of value v therefore
//   spikes floor(v*T/256) times. Events go out over a 4-phase AER link in
//   ascending address order within each timestep. Encoding stops on
//   INFERENCE_RDY or after T_MAX timesteps.
//
// Ports
//   CLK, RST        clock, asynchronous active-high reset
//   IMG_WE/WADDR/WDATA  host pixel write port (ignored while BUSY)
//   START           begin encoding the stored image (from IDLE or DONE)
//   INFERENCE_RDY   decoder has a result; stop after any open handshake
//   AERIN_ADDR/REQ  AER event address and request (registered)
//   AERIN_ACK       AER acknowledge, asynchronous, synchronised internally
//   NEW_IMAGE       one-cycle pulse on an accepted START
//   BUSY            high while encoding
//   ENC_DONE        level, encoding finished
//   TIMEOUT         finished because T_MAX was reached without inference
// ---------------------------------------------------------------------------
module aer_spike_encoder #(
  parameter int N     = 256,
  parameter int M     = 8,
  parameter int T_MAX = 64,
  parameter int TW    = 7
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         IMG_WE,
  input  logic [M-1:0] IMG_WADDR,
  input  logic [7:0]   IMG_WDATA,
  input  logic         START,
  input  logic         INFERENCE_RDY,
  output logic [M-1:0] AERIN_ADDR,
  output logic         AERIN_REQ,
  input  logic         AERIN_ACK,
  output logic         NEW_IMAGE,
  output logic         BUSY,
  output logic         ENC_DONE,
  output logic         TIMEOUT
);

  typedef enum logic [2:0] {IDLE, SCAN, REQ, ACKW, DONE} state_t;

  state_t        state, state_nxt;
  logic [M-1:0]  p, p_nxt;
  logic [TW-1:0] t, t_nxt;
  logic          ack_p0, ack_s;

  logic [M-1:0]  addr_nxt;
  logic          req_nxt, new_image_nxt, timeout_nxt, busy_nxt, done_nxt;
  logic          acc_we;

  logic [7:0]    pix [N];
  logic [7:0]    acc [N];

  logic [7:0]    acc_rd;
  logic [8:0]    sum;

  logic          last_pix, last_t, adv_end;
  logic [M-1:0]  adv_p;
  logic [TW-1:0] adv_t;

  // Accumulator is ignored on the first timestep, so stale contents from a
  // previous image never need clearing.
  always_comb begin
    acc_rd = (t == '0) ? 8'd0 : acc[p];
    sum    = {1'b0, acc_rd} + {1'b0, pix[p]};
  end

  // Next pixel position; adv_end flags that the final timestep just closed.
  always_comb begin
    last_pix = (p == M'(N - 1));
    last_t   = (t == TW'(T_MAX - 1));
    adv_p    = last_pix ? '0 : p + M'(1);
    adv_t    = last_pix ? t + TW'(1) : t;
    adv_end  = last_pix && last_t;
  end

  always_comb begin
    state_nxt     = state;
    p_nxt         = p;
    t_nxt         = t;
    addr_nxt      = AERIN_ADDR;
    req_nxt       = AERIN_REQ;
    new_image_nxt = 1'b0;
    timeout_nxt   = TIMEOUT;
    acc_we        = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (START) begin
          state_nxt     = SCAN;
          p_nxt         = '0;
          t_nxt         = '0;
          timeout_nxt   = 1'b0;
          new_image_nxt = 1'b1;
        end
      end
      SCAN: begin
        acc_we = 1'b1;
        if (INFERENCE_RDY) begin
          state_nxt   = DONE;
          timeout_nxt = 1'b0;
        end else if (sum[8]) begin
          addr_nxt  = p;
          req_nxt   = 1'b1;
          state_nxt = REQ;
        end else begin
          p_nxt = adv_p;
          t_nxt = adv_t;
          if (adv_end) begin
            state_nxt   = DONE;
            timeout_nxt = 1'b1;
          end
        end
      end
      REQ: begin
        if (ack_s) begin
          req_nxt   = 1'b0;
          state_nxt = ACKW;
        end
      end
      ACKW: begin
        // The spiking pixel's advance is deferred until the handshake closes.
        if (!ack_s) begin
          if (INFERENCE_RDY) begin
            state_nxt   = DONE;
            timeout_nxt = 1'b0;
          end else begin
            p_nxt     = adv_p;
            t_nxt     = adv_t;
            state_nxt = SCAN;
            if (adv_end) begin
              state_nxt   = DONE;
              timeout_nxt = 1'b1;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt == SCAN) || (state_nxt == REQ) || (state_nxt == ACKW);
    done_nxt = (state_nxt == DONE);
  end

  // Control registers and the ACK synchroniser
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      p          <= '0;
      t          <= '0;
      ack_p0     <= 1'b0;
      ack_s      <= 1'b0;
      AERIN_ADDR <= '0;
      AERIN_REQ  <= 1'b0;
      NEW_IMAGE  <= 1'b0;
      BUSY       <= 1'b0;
      ENC_DONE   <= 1'b0;
      TIMEOUT    <= 1'b0;
    end else begin
      state      <= state_nxt;
      p          <= p_nxt;
      t          <= t_nxt;
      ack_p0     <= AERIN_ACK;
      ack_s      <= ack_p0;
      AERIN_ADDR <= addr_nxt;
      AERIN_REQ  <= req_nxt;
      NEW_IMAGE  <= new_image_nxt;
      BUSY       <= busy_nxt;
      ENC_DONE   <= done_nxt;
      TIMEOUT    <= timeout_nxt;
    end
  end

  // Pixel and accumulator storage, deliberately left unreset
  always_ff @(posedge CLK) begin
    if (IMG_WE && ((state == IDLE) || (state == DONE))) begin
      pix[IMG_WADDR] <= IMG_WDATA;
    end
    if (acc_we) begin
      acc[p] <= sum[7:0];
    end
  end

endmodule

// File: tb/tb_aer_spike_encoder.sv
// ---------------------------------------------------------------------------
// tb_aer_spike_encoder
//   Table-driven and randomised bench for aer_spike_encoder with T_MAX=4.
//   Expected event streams come from the rate-coding rule: pixel v spikes in
//   timestep t (0-based) when floor(v*(t+1)/256) > floor(v*t/256).
// ---------------------------------------------------------------------------
module tb_aer_spike_encoder;

  localparam int N     = 256;
  localparam int M     = 8;
  localparam int T     = 4;
  localparam int TW    = 3;
  localparam int LIMIT = 20000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         img_we = 1'b0;
  logic [M-1:0] img_waddr = '0;
  logic [7:0]   img_wdata = '0;
  logic         start = 1'b0;
  logic         inf_rdy = 1'b0;
  logic [M-1:0] aer_addr;
  logic         aer_req;
  logic         aer_ack = 1'b0;
  logic         new_image, busy, enc_done, timeout;

  aer_spike_encoder #(.N(N), .M(M), .T_MAX(T), .TW(TW)) dut (
    .CLK(clk), .RST(rst),
    .IMG_WE(img_we), .IMG_WADDR(img_waddr), .IMG_WDATA(img_wdata),
    .START(start), .INFERENCE_RDY(inf_rdy),
    .AERIN_ADDR(aer_addr), .AERIN_REQ(aer_req), .AERIN_ACK(aer_ack),
    .NEW_IMAGE(new_image), .BUSY(busy), .ENC_DONE(enc_done), .TIMEOUT(timeout)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  int img [N];
  int got_q [$];
  int exp_q [$];
  logic [M-1:0] lat_addr;
  bit addr_bad = 0;
  bit req_q = 0;

  typedef struct {
    int a0; int v0; int a1; int v1;
    int n_ev; bit to; int cyc;
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Rate-coding reference: full ordered event list for the current image.
  task automatic build_exp();
    exp_q.delete();
    for (int tt = 0; tt < T; tt++)
      for (int pp = 0; pp < N; pp++)
        if ((img[pp] * (tt + 1)) / 256 > (img[pp] * tt) / 256) exp_q.push_back(pp);
  endtask

  task automatic load_img();
    for (int pp = 0; pp < N; pp++) begin
      img_waddr = pp[M-1:0];
      img_wdata = img[pp][7:0];
      img_we = 1'b1;
      @(negedge clk);
    end
    img_we = 1'b0;
  endtask

  task automatic clear_img();
    for (int pp = 0; pp < N; pp++) img[pp] = 0;
  endtask

  // AER responder: 3-cycle delay on each phase.
  initial begin
    forever begin
      @(negedge clk);
      if (aer_req && !aer_ack) begin
        repeat (3) @(negedge clk);
        aer_ack = 1'b1;
      end else if (!aer_req && aer_ack) begin
        repeat (3) @(negedge clk);
        aer_ack = 1'b0;
      end
    end
  end

  // Event monitor
  initial begin
    forever begin
      @(negedge clk);
      if (aer_req && !req_q) begin
        got_q.push_back(int'(aer_addr));
        lat_addr = aer_addr;
      end
      if (aer_req && req_q && (aer_addr !== lat_addr)) addr_bad = 1;
      if (!aer_req && req_q && !rst) check("req_fall_after_ack", aer_ack, 1);
      req_q = aer_req;
    end
  end

  // mode 0: plain run, 1: INFERENCE_RDY on first REQ, 2: START/IMG_WE poked
  // while busy, 3: INFERENCE_RDY at scan cycle 100
  task automatic run_enc(input int mode, input bit exp_to, input int exp_cyc, input int exp_n);
    int cyc;
    int eq [$];
    build_exp();
    eq.delete();
    if (mode == 0 || mode == 2) eq = exp_q;
    else if (mode == 1 && exp_q.size() > 0) eq.push_back(exp_q[0]);
    got_q.delete();
    addr_bad = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    check("new_image_pulse", new_image, 1);
    check("busy_after_start", busy, 1);
    check("done_cleared", enc_done, 0);
    check("timeout_cleared", timeout, 0);
    while (!enc_done && cyc < LIMIT) begin
      if (mode == 1 && aer_req) inf_rdy = 1'b1;
      if (mode == 3 && cyc == 100) inf_rdy = 1'b1;
      if (mode == 2 && cyc == 10) begin
        start = 1'b1;
        img_we = 1'b1;
        img_waddr = 8'd5;
        img_wdata = 8'd255;
      end
      @(negedge clk);
      cyc++;
      if (mode == 2 && cyc == 11) begin
        start = 1'b0;
        img_we = 1'b0;
      end
      if (cyc == 1 || (mode == 2 && cyc == 11)) check("new_image_single", new_image, 0);
    end
    check("enc_done", enc_done, 1);
    check("busy_low_when_done", busy, 0);
    check("req_low_when_done", aer_req, 0);
    check("timeout_flag", timeout, exp_to);
    if (exp_cyc > 0) check("run_cycles", cyc, exp_cyc);
    if (exp_n >= 0) check("event_count_table", got_q.size(), exp_n);
    if (mode == 1) check("ack_low_at_done", aer_ack, 0);
    check("addr_stable", addr_bad, 0);
    check("event_count_model", got_q.size(), eq.size());
    for (int i = 0; i < got_q.size() && i < eq.size(); i++) check("event_addr", got_q[i], eq[i]);
  endtask

  initial begin
    vecs[0] = '{a0: 0,   v0: 0,   a1: 0,   v1: 0,   n_ev: 0, to: 1, cyc: 4 * N};
    vecs[1] = '{a0: 5,   v0: 128, a1: 5,   v1: 128, n_ev: 2, to: 1, cyc: 0};
    vecs[2] = '{a0: 3,   v0: 255, a1: 200, v1: 64,  n_ev: 4, to: 1, cyc: 0};
    vecs[3] = '{a0: 0,   v0: 1,   a1: 255, v1: 192, n_ev: 3, to: 1, cyc: 0};
    vecs[4] = '{a0: 10,  v0: 63,  a1: 11,  v1: 64,  n_ev: 1, to: 1, cyc: 0};
    vecs[5] = '{a0: 254, v0: 255, a1: 255, v1: 255, n_ev: 6, to: 1, cyc: 0};

    repeat (3) @(negedge clk);
    check("rst_req", aer_req, 0);
    check("rst_addr", aer_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", enc_done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_new_image", new_image, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      clear_img();
      img[vecs[v].a0] = vecs[v].v0;
      img[vecs[v].a1] = vecs[v].v1;
      load_img();
      run_enc(0, vecs[v].to, vecs[v].cyc, vecs[v].n_ev);
      repeat (3) @(negedge clk);
    end

    for (int r = 0; r < 2; r++) begin
      for (int pp = 0; pp < N; pp++) img[pp] = int'($urandom_range(0, 255));
      load_img();
      run_enc(0, 1, 0, -1);
      repeat (3) @(negedge clk);
    end

    // Inference raised during an open handshake
    clear_img();
    img[3] = 255;
    img[200] = 64;
    load_img();
    run_enc(1, 0, 0, 1);
    repeat (40) @(negedge clk);
    check("no_req_after_inference", got_q.size(), 1);
    inf_rdy = 1'b0;
    repeat (3) @(negedge clk);

    // Inference during a plain scan
    clear_img();
    load_img();
    run_enc(3, 0, 101, 0);
    inf_rdy = 1'b0;
    repeat (3) @(negedge clk);

    // START / IMG_WE while busy, then rerun to show pix unchanged
    clear_img();
    img[5] = 128;
    load_img();
    run_enc(2, 1, 0, 2);
    repeat (3) @(negedge clk);
    run_enc(0, 1, 0, 2);
    repeat (3) @(negedge clk);

    // Reset in the middle of a handshake
    begin
      int k;
      clear_img();
      img[3] = 255;
      load_img();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!aer_req && k < 3000) begin
        @(negedge clk);
        k++;
      end
      check("rst_test_req_seen", aer_req, 1);
      rst = 1'b1;
      #1;
      check("async_rst_req", aer_req, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_done", enc_done, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      k = 0;
      while ((aer_ack || k < 5) && k < 100) begin
        @(negedge clk);
        k++;
      end
      check("ack_idle_after_rst", aer_ack, 0);
      run_enc(0, 1, 0, 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/aer_spike_encoder.md
Name: aer_spike_encoder

Overview:
Upstream stage of the SNN accelerator. It stores one input image and converts pixel intensities into input spike events by deterministic rate coding. It delivers those events to the tinyODIN core over a 4-phase AER-in link, one timestep at a time. Encoding stops when the downstream decoder raises INFERENCE_RDY, or when T_MAX timesteps have elapsed.

Parameters:
N, 256, number of pixels / input neurons
M, 8, address width, log2(N)
T_MAX, 64, maximum number of timesteps per image (>=1)
TW, 7, timestep counter width, clog2(T_MAX+1)

Ports:
CLK  input  1  clock
RST  input  1  reset, asynchronous, active-high
IMG_WE  input  1  pixel write strobe (host side)
IMG_WADDR  input  M  pixel address
IMG_WDATA  input  8  pixel intensity, 0..255
START  input  1  begin encoding the stored image
INFERENCE_RDY  input  1  decoder has stored a class; stop encoding
AERIN_ADDR  output  M  spiking pixel address
AERIN_REQ  output  1  AER request
AERIN_ACK  input  1  AER acknowledge (asynchronous domain)
NEW_IMAGE  output  1  one-cycle pulse to the decoder on accepted START
BUSY  output  1  high while encoding
ENC_DONE  output  1  encoding finished (level)
TIMEOUT  output  1  finished because T_MAX was reached without inference

Behaviour:
- Reset: all outputs 0, state IDLE, pixel/timestep counters 0. Pixel and accumulator arrays are not reset. Reset mid-handshake drops AERIN_REQ immediately (async).
- AERIN_ACK passes through a 2-flop synchroniser (ack_s); the FSM uses only ack_s.
- Storage: pix[N] x 8 bit and acc[N] x 8 bit register arrays. IMG_WE writes pix[IMG_WADDR] only in IDLE or DONE; writes are ignored while BUSY.
- States: IDLE, SCAN, REQ, ACKW, DONE.
- IDLE/DONE + START: go to SCAN with p=0, t=0. Clear ENC_DONE and TIMEOUT. NEW_IMAGE=1 for exactly the next cycle. BUSY=1 from the next cycle onward. START in any other state is ignored.
- SCAN, one pixel per cycle:
  - sum[8:0] = (t==0 ? 0 : acc[p]) + pix[p]; acc[p] <= sum[7:0].
  - If INFERENCE_RDY=1: go to DONE. Do not evaluate a spike; TIMEOUT=0.
  - Else if sum[8]=1: latch AERIN_ADDR<=p and go to REQ. AERIN_REQ is registered high on the next cycle.
  - Else advance the pixel.
- Pixel advance: if p<N-1, p++. Else p=0 and t++. If t+1==T_MAX, go to DONE with TIMEOUT=1.
- REQ: AERIN_REQ=1 and AERIN_ADDR held stable. When ack_s=1, drop REQ and go to ACKW.
- ACKW: wait for ack_s=0, then:
  - INFERENCE_RDY=1 -> DONE (TIMEOUT=0);
  - else perform the pixel advance and return to SCAN (or go to DONE if T_MAX is reached).
- INFERENCE_RDY rising during REQ/ACKW: the handshake is always completed first. No further REQ is issued after that.
- DONE: ENC_DONE=1, BUSY=0, REQ=0. Hold until START or reset.
- Events within a timestep are emitted in ascending address order, at most one per pixel per timestep.
- Spike count for pixel value v after T timesteps = floor(v*T/256). Pixel 0 never spikes.
- Timing: a timestep without spikes takes exactly N SCAN cycles. Each spike adds REQ+ACKW cycles, minimum 2 synchroniser delays per phase.

Test Plan:
- All pix=0, T_MAX=4, START -> NEW_IMAGE one cycle, no AERIN_REQ, ENC_DONE=1 and TIMEOUT=1 exactly 4*N cycles after SCAN entry; BUSY=0 in the cycle after.
- pix[5]=128, others 0, T_MAX=4, ACK responder 3-cycle delay -> exactly 2 events, ADDR=5, in timesteps 1 and 3. ADDR stable while REQ high. REQ falls only after ACK seen.
- pix[3]=255, pix[200]=64, T_MAX=4 -> pixel 3 events in t=1,2,3; pixel 200 event in t=3 only. Order within t=3 is 3 then 200. Total 4 events.
- Raise INFERENCE_RDY while REQ=1 -> handshake completes (REQ falls after ACK, ACK returns low). Then DONE with TIMEOUT=0 and no further REQ even with pending spikes.
- START and IMG_WE pulsed while BUSY -> no restart, no NEW_IMAGE, pix unchanged (read back via the next encoding run).
- Assert RST while REQ=1 -> REQ=0, BUSY=0, ENC_DONE=0 immediately. A new START after release runs normally from t=0.
